// File: rtl/divisor_seq_8bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// A division by zero skips the iteration phase and reports all-ones
// quotient with the dividend as remainder. The done strobe is meant to
// serve directly as the load enable of a downstream result register.
module divisor_seq_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dz;

    logic             w_zero;
    logic             w_last;
    logic [WIDTH:0]   w_p_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_p_next;
    logic [WIDTH-1:0] w_a_next;

    // The partial remainder stays below the divisor after every restore step,
    // so it is kept WIDTH bits wide; only the shifted value needs the extra bit.
    assign w_zero    = (divisor == '0);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_p_shift = {r_p, r_a[WIDTH-1]};
    assign w_ge      = (w_p_shift >= {1'b0, r_d});
    assign w_p_next  = w_ge ? (w_p_shift[WIDTH-1:0] - r_d) : w_p_shift[WIDTH-1:0];
    assign w_a_next  = {r_a[WIDTH-2:0], w_ge};

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_p    <= '0;
            r_a    <= '0;
            r_d    <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_zero) begin
                            r_quot <= '1;
                            r_rem  <= dividend;
                            r_dz   <= 1'b1;
                        end else begin
                            r_a   <= dividend;
                            r_d   <= divisor;
                            r_p   <= '0;
                            r_cnt <= '0;
                        end
                    end
                end
                S_CALC: begin
                    r_p   <= w_p_next;
                    r_a   <= w_a_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_quot <= w_a_next;
                        r_rem  <= w_p_next;
                        r_dz   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign div_zero  = r_dz;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule
